led_step_ctrl: RTL

LED_STEP_CTRL -- requirements
Module: led_step_ctrl

---
 rtl/led_step_ctrl_if.sv | 26 ++
 rtl/led_step_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/led_step_ctrl_if.sv
// rtl/led_step_ctrl_if.sv - button/auto inputs and LED status outputs of led_step_ctrl
// Signals:
//   p_up, p_dn   raw pushbuttons (asynchronous, active-high)
//   auto_en      auto step-up enable level
//   Led          current 2-bit step state
//   step_pulse   one-cycle strobe when Led changes
//   busy         high while the stepper is locked out
// master drives the inputs and observes status; slave is the controller.
interface led_step_ctrl_if;
  logic       p_up;
  logic       p_dn;
  logic       auto_en;
  logic [1:0] Led;
  logic       step_pulse;
  logic       busy;

  modport master (
    output p_up, p_dn, auto_en,
    input  Led, step_pulse, busy
  );

  modport slave (
    input  p_up, p_dn, auto_en,
    output Led, step_pulse, busy
  );
endinterface

// File: rtl/led_step_ctrl.sv
// rtl/led_step_ctrl.sv - two-bit LED stepper with debounced buttons, lockout and auto-advance
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-low reset
//   io   led_step_ctrl_if.slave: p_up/p_dn/auto_en in, Led/step_pulse/busy out
module led_step_ctrl #(
  parameter int DEB_CYCLES  = 100000,
  parameter int LOCK_CYCLES = 1000000,
  parameter int AUTO_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  led_step_ctrl_if.slave    io
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int AW = $clog2(AUTO_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0]         btn_raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         acc;
  logic [1:0]         req;
  logic [1:0][DW-1:0] deb_cnt;

  state_t             state;
  state_t             state_nxt;
  logic [LW-1:0]      lock_cnt;
  logic [AW-1:0]      auto_cnt;
  logic               last_up;
  logic               manual_any;
  logic               auto_req;
  logic               do_up;
  logic               do_dn;
  logic               rr_upd;
  logic [1:0]         led_q;
  logic [1:0]         led_nxt;
  logic               step_q;
  logic               busy_o;

  assign btn_raw = {io.p_dn, io.p_up};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted on the DEB_CYCLES-th consecutive cycle that it
  // differs from the accepted one; any agreeing cycle restarts the count.
  // Only the rising acceptance raises a request, one cycle wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt <= '0;
      acc     <= '0;
      req     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          acc[i]     <= sync2[i];
          req[i]     <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign manual_any = |req;

  // Any manual request, even one dropped in lockout, restarts the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt <= '0;
    end else if (!io.auto_en || manual_any) begin
      auto_cnt <= '0;
    end else if (auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign auto_req = io.auto_en && !manual_any && (auto_cnt == AUTO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      led_q    <= 2'b00;
      step_q   <= 1'b0;
      last_up  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= (state == LOCK && state_nxt == LOCK) ? lock_cnt + 1'b1 : '0;
      led_q    <= led_nxt;
      step_q   <= do_up | do_dn;
      if (rr_upd) begin
        last_up <= do_up;
      end
    end
  end

  // Requests are only honoured in IDLE; everything seen in LOCK is lost.
  // A tie goes to the direction not granted last; auto never touches last_up.
  always_comb begin
    state_nxt = state;
    do_up     = 1'b0;
    do_dn     = 1'b0;
    rr_upd    = 1'b0;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) begin
          do_up  = !last_up;
          do_dn  = last_up;
          rr_upd = 1'b1;
        end else if (req[0]) begin
          do_up  = 1'b1;
          rr_upd = 1'b1;
        end else if (req[1]) begin
          do_dn  = 1'b1;
          rr_upd = 1'b1;
        end else if (auto_req) begin
          do_up  = 1'b1;
        end
        if (do_up || do_dn) begin
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    busy_o  = (state == LOCK);
    led_nxt = led_q;
    if (do_up) begin
      led_nxt = led_q + 2'd1;
    end else if (do_dn) begin
      led_nxt = led_q - 2'd1;
    end
  end

  assign io.Led        = led_q;
  assign io.step_pulse = step_q;
  assign io.busy       = busy_o;

endmodule
